// File: rtl/dma_pkg.sv
// Shared definitions for the AXI read DMA and its downstream line packer.
package dma_pkg;

  // Defaults shared with the DMA so both sides agree on word and count widths.
  localparam int unsigned DMA_DATA_W     = 32;
  localparam int unsigned DMA_PACK       = 4;
  localparam int unsigned DMA_BITS_TRANS = 18;
  localparam int unsigned LANE_W         = $clog2(DMA_PACK);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFlush,
    StFin
  } dma_state_e;

endpackage

// File: rtl/dma_pack_lane.sv
// Lane register that gathers PACK words into one buffer line.
// line_o is the line as it will look after this cycle's write, so the
// completing word can be emitted in the same cycle it arrives.
module dma_pack_lane
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W = DMA_DATA_W,
  parameter int unsigned PACK   = DMA_PACK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     wr_i,
  input  logic [$clog2(PACK)-1:0]  lane_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     emit_i,
  output logic [PACK*DATA_W-1:0]   line_o
);

  logic [PACK*DATA_W-1:0] lanes_q;

  // Merge the incoming word into its lane.
  always_comb begin
    line_o = lanes_q;
    if (wr_i) begin
      line_o[DATA_W*lane_i +: DATA_W] = data_i;
    end
  end

  // Clearing on emit means any lane not refilled reads back as zero padding.
  always_ff @(posedge clk) begin
    if (rst || clr_i || emit_i) begin
      lanes_q <= '0;
    end else if (wr_i) begin
      lanes_q <= line_o;
    end
  end

endmodule

// File: rtl/dma_rd_packer.sv
// Packs the DMA word stream into wide lines and writes them to a line buffer.
module dma_rd_packer
  import dma_pkg::*;
#(
  parameter int unsigned DATA_W     = DMA_DATA_W,
  parameter int unsigned PACK       = DMA_PACK,
  parameter int unsigned BUF_AW     = 12,
  parameter int unsigned BITS_TRANS = DMA_BITS_TRANS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [BUF_AW-1:0]      base_addr_i,
  input  logic [BITS_TRANS-1:0]  num_words_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   data_vld_i,
  input  logic                   done_i,
  output logic                   buf_we_o,
  output logic [BUF_AW-1:0]      buf_addr_o,
  output logic [PACK*DATA_W-1:0] buf_wdata_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned LaneW = $clog2(PACK);
  localparam int unsigned LineW = PACK * DATA_W;

  dma_state_e            state_q, state_d;
  logic [BITS_TRANS-1:0] cnt_q, cnt_d, num_q, num_d, cnt_inc;
  logic [BUF_AW-1:0]     addr_q, addr_d;
  logic                  err_q, err_d;
  // Set by the first start; lets stray words right after reset go unflagged.
  logic                  armed_q, armed_d;

  logic                  lane_wr, lane_clr, emit;
  logic [LaneW-1:0]      lane;
  logic                  line_full, last_word;
  logic [LineW-1:0]      line_next;

  logic                  we_q, done_q;
  logic [BUF_AW-1:0]     baddr_q;
  logic [LineW-1:0]      wdata_q;

  assign cnt_inc   = cnt_q + BITS_TRANS'(1);
  assign lane      = cnt_q[LaneW-1:0];
  assign line_full = (lane == LaneW'(PACK - 1));
  assign last_word = (cnt_inc == num_q);

  dma_pack_lane #(
    .DATA_W (DATA_W),
    .PACK   (PACK)
  ) u_lane (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (lane_clr),
    .wr_i   (lane_wr),
    .lane_i (lane),
    .data_i (data_i),
    .emit_i (emit),
    .line_o (line_next)
  );

  // Next-state, counter, address and error decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    addr_d   = addr_q;
    err_d    = err_q;
    armed_d  = armed_q;
    lane_wr  = 1'b0;
    lane_clr = 1'b0;
    emit     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          num_d    = num_words_i;
          addr_d   = base_addr_i;
          cnt_d    = '0;
          lane_clr = 1'b1;
          err_d    = 1'b0;
          armed_d  = 1'b1;
          state_d  = (num_words_i == '0) ? StFin : StFill;
        end else if (data_vld_i && armed_q) begin
          err_d = 1'b1;
        end
      end
      StFill: begin
        if (data_vld_i) begin
          lane_wr = 1'b1;
          cnt_d   = cnt_inc;
          emit    = line_full;
          if (last_word) begin
            state_d = line_full ? StFin : StFlush;
          end else if (done_i) begin
            // Early end: the word just taken is pending unless it closed a line.
            err_d   = 1'b1;
            state_d = line_full ? StFin : StFlush;
          end
        end else if (done_i) begin
          err_d   = 1'b1;
          state_d = (lane != '0) ? StFlush : StFin;
        end
      end
      StFlush: begin
        emit    = 1'b1;
        state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
        if (data_vld_i) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (emit) begin
      addr_d = addr_q + BUF_AW'(1);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      num_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  // Registered buffer write port and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      baddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      we_q   <= emit;
      done_q <= (state_q == StFin);
      if (emit) begin
        baddr_q <= addr_q;
        wdata_q <= line_next;
      end
    end
  end

  assign buf_we_o    = we_q;
  assign buf_addr_o  = baddr_q;
  assign buf_wdata_o = wdata_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/dma_rd_packer.md
# dma_rd_packer

Downstream stage of the AXI read DMA. Consumes the DMA's registered 32-bit word stream (`data`/`valid`/`done`) and packs every PACK consecutive words into one wide line. Writes each line into an on-chip line buffer (weight or input-feature-map SRAM) at incrementing addresses. Zero-pads and flushes a partial tail line, and flags count mismatches between the programmed transfer length and what the DMA actually delivered.

## Interface
- DATA_W, 32, width of one DMA word
- PACK, 4, words per buffer line (power of two, 2..16)
- BUF_AW, 12, buffer address width
- BITS_TRANS, 18, width of the word-count field (matches the DMA's count width)
- Reset is synchronous and active-high; one clock, `clk`, for the whole block.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse; latches base_addr_i and num_words_i; driven by the same pulse that starts the DMA
- base_addr_i  in  BUF_AW  first buffer line address
- num_words_i  in  BITS_TRANS  expected number of DATA_W words
- data_i  in  DATA_W  word from DMA
- data_vld_i  in  1  word valid; no backpressure, every valid word must be accepted
- done_i  in  1  DMA end-of-transfer pulse
- buf_we_o  out  1  line write enable
- buf_addr_o  out  BUF_AW  line address
- buf_wdata_o  out  PACK*DATA_W  packed line
- busy_o  out  1  high from the cycle after start_i until done_o
- done_o  out  1  one-cycle pulse after the final line write
- err_o  out  1  sticky mismatch flag; cleared by start_i or rst

## Operation
- States:
  - IDLE: wait for start_i.
  - FILL: accept words.
  - FLUSH: emit the partial line.
  - FIN: pulse done_o, then return to IDLE.
- start_i in IDLE:
  - Latches base address and count.
  - Clears the word counter, lane index, lane register and err_o.
  - If num_words_i == 0: go to FIN.
  - Otherwise: go to FILL.
- start_i outside IDLE is ignored.
- Word packing in FILL:
  - Each valid word goes to lane = word_cnt mod PACK, at bits [DATA_W*lane +: DATA_W]. Lane 0 holds the lowest bits.
  - word_cnt increments on each valid word.
- Line completion:
  - When lane PACK-1 is filled, or the last expected word arrives, a write is issued.
  - Unfilled lanes are written as zero.
  - The line address then increments, wrapping modulo 2^BUF_AW.
- Last word (word_cnt reaches num_words):
  - If it completes a full line: go to FIN.
  - Otherwise: go to FLUSH, which takes one cycle and writes the padded line.
- done_i arriving before the count is reached:
  - Set err_o.
  - If lanes are pending: go to FLUSH. Otherwise: go to FIN.
- data_vld_i in IDLE or FIN (surplus words): set err_o if the block is not in IDLE after reset; drop the data.
- done_i after the count is complete: no effect.
- Reset mid-transfer: all state goes to IDLE and the partial line is discarded without a write.

## Timing
- Reset values:
  - buf_we_o = 0, buf_addr_o = 0, buf_wdata_o = 0.
  - busy_o = 0, done_o = 0, err_o = 0.
- Write latency:
  - buf_we_o/addr/wdata are registered.
  - The write appears on the cycle after the clock edge that accepts the completing word.
  - buf_we_o is high for exactly one cycle per line.
- Throughput: one word per cycle sustained, with no bubbles; back-to-back full lines give buf_we_o on consecutive PACK-cycle boundaries.
- Flush: a partial tail is written 1 cycle after the last word would have been accepted, i.e. from the FLUSH state.
- done_o:
  - Occurs the cycle after the final buf_we_o.
  - For num_words == 0, it occurs 2 cycles after start_i.
- err_o: asserts on the cycle after the offending event and holds.
- Simultaneous start_i and data_vld_i in IDLE: start wins and that word is dropped. The DMA's registered valid is at least 3 cycles after start, so this only occurs on misuse.
- Line count = ceil(num_words / PACK), computed with BITS_TRANS-wide arithmetic; no truncation.

## Structure
- Shared package `dma_pkg`:
  - State enum (IDLE, FILL, FLUSH, FIN).
  - Default DATA_W/PACK/BITS_TRANS constants, shared with the DMA.
  - LANE_W = $clog2(PACK).
- Sub-module `dma_pack_lane`:
  - PACK×DATA_W lane register with a per-lane write and a clear-on-emit control.
  - Clear-on-emit lets zero padding come free.
- The top holds the FSM, counters, address register and error logic.

## Test plan
- PACK=4, num_words=8, base 0x010, words 1..8 back-to-back → writes at 0x010 = {4,3,2,1} and 0x011 = {8,7,6,5}; done_o one cycle after the second write; err_o=0.
- num_words=6, words with gaps of 2 idle cycles → 0x010 = {4,3,2,1}, 0x011 = {0,0,6,5} written via FLUSH; done_o follows.
- num_words=0 → no buf_we_o; done_o 2 cycles after start_i; busy_o high for 1 cycle.
- num_words=8, DMA sends 5 words then done_i → 0x010 = {4,3,2,1}, 0x011 = {0,0,0,5}; err_o=1 until the next start_i.
- base 0xFFF, num_words=8 → writes at 0xFFF then 0x000 (wrap).
- rst asserted after 3 words of an 8-word transfer → no write; all outputs 0; a fresh start completes normally with err_o=0.
